// File: rtl/jt900h_pkg.sv
// Shared definitions for the jt900h CPU core: default opcode queue sizing
// and the byte-consumption encoding exchanged between jt900h_ctrl and jt900h_opq.
package jt900h_pkg;

  localparam int unsigned OPQ_QLEN = 8;
  localparam int unsigned OPQ_AW   = 24;

  typedef enum logic [1:0] {
    FETCH_NONE  = 2'd0,
    FETCH_ONE   = 2'd1,
    FETCH_TWO   = 2'd2,
    FETCH_THREE = 2'd3
  } fetch_e;

endpackage

// File: rtl/jt900h_opq.sv
// Opcode prefetch queue: reads 16-bit program words into a byte queue and
// presents the next four opcode bytes at pc to the controller.
module jt900h_opq
  import jt900h_pkg::*;
#(
  parameter int unsigned QLEN = OPQ_QLEN,
  parameter int unsigned AW   = OPQ_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          pc_we,
  input  logic [AW-1:0] pc_din,
  output logic [AW-1:0] pc,
  input  logic [1:0]    fetched,
  output logic [31:0]   op,
  output logic          op_ok,
  output logic [AW-1:0] bus_addr,
  output logic          bus_rd,
  input  logic [15:0]   bus_din,
  input  logic          bus_ok
);

  localparam int unsigned CW = $clog2(QLEN + 1);

  logic [QLEN-1:0][7:0] q_q, q_d, shifted;
  logic [8*QLEN-1:0]    app_ext;
  logic [CW-1:0]        count_q, count_d, rem, app_n;
  logic [AW-1:0]        pc_q, pc_d, fa_q, fa_d, bus_addr_q, bus_addr_d;
  logic                 skip_q, skip_d, discard_q, discard_d;
  logic                 bus_rd_q, bus_rd_d, op_ok_q, op_ok_d;
  logic [31:0]          op_q, op_d;
  logic [1:0]           cons;
  logic                 accept, hold, fill;

  always_comb begin
    cons    = (op_ok_q && fetch_e'(fetched) != FETCH_NONE) ? fetched : 2'd0;
    accept  = bus_rd_q && bus_ok;
    hold    = bus_rd_q && !bus_ok;
    fill    = accept && !discard_q && !pc_we;
    rem     = count_q - CW'(cons);
    app_n   = fill ? (skip_q ? CW'(1) : CW'(2)) : '0;
    app_ext = '0;
    app_ext[15:0] = skip_q ? {8'h00, bus_din[15:8]} : bus_din;

    // Bytes at and above count are kept at zero, so shifting pulls in zeros
    // and new bytes can simply be OR-ed in above the surviving ones.
    shifted = q_q >> {cons, 3'b000};
    q_d     = fill ? (shifted | (app_ext << {rem, 3'b000})) : shifted;
    count_d = rem + app_n;
    pc_d    = pc_q + AW'(cons);
    fa_d    = fill ? fa_q + AW'(2) : fa_q;
    skip_d  = fill ? 1'b0 : skip_q;
    discard_d = accept ? 1'b0 : discard_q;

    if (pc_we) begin
      q_d       = '0;
      count_d   = '0;
      pc_d      = pc_din;
      fa_d      = {pc_din[AW-1:1], 1'b0};
      skip_d    = pc_din[0];
      discard_d = hold;
    end

    // A waiting request keeps its address even across a flush.
    if (hold) begin
      bus_rd_d   = 1'b1;
      bus_addr_d = bus_addr_q;
    end else begin
      bus_rd_d   = (count_d <= CW'(QLEN - 2)) && !discard_d;
      bus_addr_d = fa_d;
    end

    op_d    = q_d[3:0];
    op_ok_d = count_d >= CW'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= '0;
      count_q    <= '0;
      pc_q       <= '0;
      fa_q       <= '0;
      skip_q     <= 1'b0;
      discard_q  <= 1'b0;
      bus_rd_q   <= 1'b0;
      bus_addr_q <= '0;
      op_q       <= '0;
      op_ok_q    <= 1'b0;
    end else if (cen) begin
      q_q        <= q_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      fa_q       <= fa_d;
      skip_q     <= skip_d;
      discard_q  <= discard_d;
      bus_rd_q   <= bus_rd_d;
      bus_addr_q <= bus_addr_d;
      op_q       <= op_d;
      op_ok_q    <= op_ok_d;
    end
  end

  assign pc       = pc_q;
  assign op       = op_q;
  assign op_ok    = op_ok_q;
  assign bus_addr = bus_addr_q;
  assign bus_rd   = bus_rd_q;

endmodule

// File: tb/tb_jt900h_opq.sv
// Directed bench for jt900h_opq: a program memory model answers bus reads and a
// scoreboard of expected pc/op values is checked after each consume step.
module tb_jt900h_opq;
  import jt900h_pkg::*;

  localparam int unsigned AW = 24;

  logic          clk = 1'b0;
  logic          rst, cen, pc_we, bus_rd, bus_ok, op_ok;
  logic [AW-1:0] pc_din, pc, bus_addr;
  logic [1:0]    fetched;
  logic [31:0]   op;
  logic [15:0]   bus_din;

  int            n_chk = 0, n_fail = 0;
  int            hold_cnt;
  bit            drop_pending;
  logic [AW-1:0] exp_fa, exp_pc, old_fa;
  logic [31:0]   saved_op;

  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   op;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  jt900h_opq #(.QLEN(8), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .pc_we(pc_we), .pc_din(pc_din), .pc(pc),
    .fetched(fetched), .op(op), .op_ok(op_ok), .bus_addr(bus_addr),
    .bus_rd(bus_rd), .bus_din(bus_din), .bus_ok(bus_ok)
  );

  // 0x100..0x10E hold 11 22 33 .. FF; elsewhere a simple address pattern.
  function automatic logic [7:0] mem(input logic [AW-1:0] a);
    logic [7:0] k;
    k = a[7:0] + 8'd1;
    if (a >= 24'h100 && a <= 24'h10E) return 8'(k * 8'h11);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] exp_op(input logic [AW-1:0] p);
    return {mem(p + 24'd3), mem(p + 24'd2), mem(p + 24'd1), mem(p)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: the memory answers a visible request unless held off, and
  // tracks which address the next useful read must use.
  task automatic tick();
    logic ack;
    ack     = cen && bus_rd && hold_cnt == 0;
    bus_ok  = ack;
    bus_din = ack ? {mem(bus_addr + 24'd1), mem(bus_addr)} : 16'h0000;
    if (ack) begin
      if (drop_pending) drop_pending = 1'b0;
      else begin
        chk("bus_addr at ack", 32'(bus_addr), 32'(exp_fa));
        exp_fa = exp_fa + 24'd2;
      end
    end else if (cen && bus_rd && hold_cnt > 0) hold_cnt--;
    if (pc_we && cen) begin
      if (bus_rd && !ack) drop_pending = 1'b1;
      exp_fa = {pc_din[AW-1:1], 1'b0};
      exp_pc = pc_din;
    end
    if (rst) begin
      exp_fa = '0;
      exp_pc = '0;
      drop_pending = 1'b0;
    end
    @(posedge clk);
    #1;
    bus_ok  = 1'b0;
    pc_we   = 1'b0;
    fetched = 2'd0;
  endtask

  task automatic consume(input logic [1:0] n);
    exp_t e;
    chk("op_ok before fetched", 32'(op_ok), 32'd1);
    exp_pc = exp_pc + AW'(n);
    sb.push_back('{exp_pc, exp_op(exp_pc)});
    fetched = n;
    tick();
    e = sb.pop_front();
    chk("pc after consume", 32'(pc), 32'(e.pc));
    if (op_ok) chk("op after consume", op, e.op);
  endtask

  task automatic wait_full();
    int k;
    k = 0;
    while (!(op_ok === 1'b1 && bus_rd === 1'b0) && k < 20) begin
      tick();
      k++;
    end
    chk("queue full within budget", 32'(k < 20), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " pc"}, 32'(pc), 32'd0);
    chk({tag, " bus_addr"}, 32'(bus_addr), 32'd0);
    chk({tag, " bus_rd"}, 32'(bus_rd), 32'd0);
    chk({tag, " op"}, op, 32'd0);
    chk({tag, " op_ok"}, 32'(op_ok), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; pc_we = 1'b0; pc_din = '0; fetched = 2'd0;
    bus_ok = 1'b0; bus_din = '0; hold_cnt = 0; drop_pending = 1'b0;
    exp_fa = '0; exp_pc = '0;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Even-target flush and refill
    pc_we = 1'b1; pc_din = 24'h000100;
    tick();
    chk("t1 bus_rd", 32'(bus_rd), 32'd1);
    chk("t1 bus_addr", 32'(bus_addr), 32'h100);
    chk("t1 op_ok flush", 32'(op_ok), 32'd0);
    tick();
    chk("t1 op_ok 1st word", 32'(op_ok), 32'd0);
    tick();
    chk("t1 op_ok", 32'(op_ok), 32'd1);
    chk("t1 op", op, 32'h44332211);
    chk("t1 pc", 32'(pc), 32'h100);

    // Odd target; the flush coincides with an ack whose data is dropped
    pc_we = 1'b1; pc_din = 24'h000101;
    tick();
    chk("t2 bus_addr", 32'(bus_addr), 32'h100);
    chk("t2 op_ok flush", 32'(op_ok), 32'd0);
    tick();
    chk("t2 op_ok w1", 32'(op_ok), 32'd0);
    tick();
    chk("t2 op_ok w2", 32'(op_ok), 32'd0);
    tick();
    chk("t2 op_ok", 32'(op_ok), 32'd1);
    chk("t2 op", op, 32'h55443322);
    chk("t2 pc", 32'(pc), 32'h101);

    // Steady stream with mixed consumption and one stalled clock enable
    pc_we = 1'b1; pc_din = 24'h000100;
    tick();
    wait_full();
    chk("t3 op full", op, 32'h44332211);
    cen = 1'b0; fetched = 2'd2;
    tick();
    cen = 1'b1;
    chk("t3 pc cen=0", 32'(pc), 32'h100);
    chk("t3 op cen=0", op, 32'h44332211);
    consume(2'd1);
    consume(2'd2);
    consume(2'd3);
    consume(2'd1);
    chk("t3 final pc", 32'(pc), 32'h107);

    // Flush while a read is held off: stale data must not reach the queue
    chk("t4 pending", 32'(bus_rd), 32'd1);
    old_fa = exp_fa;
    hold_cnt = 3;
    pc_we = 1'b1; pc_din = 24'h000200;
    tick();
    chk("t4 op_ok flush", 32'(op_ok), 32'd0);
    chk("t4 bus_rd held", 32'(bus_rd), 32'd1);
    chk("t4 bus_addr held", 32'(bus_addr), 32'(old_fa));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4 op_ok stale", 32'(op_ok), 32'd0);
    end
    chk("t4 new bus_rd", 32'(bus_rd), 32'd1);
    chk("t4 new bus_addr", 32'(bus_addr), 32'h200);
    tick();
    chk("t4 op_ok w1", 32'(op_ok), 32'd0);
    tick();
    chk("t4 op_ok", 32'(op_ok), 32'd1);
    chk("t4 op", op, exp_op(24'h200));
    chk("t4 pc", 32'(pc), 32'h200);

    // Full queue idles without requests; reads resume at QLEN-2
    wait_full();
    saved_op = op;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5 bus_rd full", 32'(bus_rd), 32'd0);
      chk("t5 op stable", op, saved_op);
    end
    consume(2'd1);
    chk("t5 bus_rd at QLEN-1", 32'(bus_rd), 32'd0);
    consume(2'd1);
    chk("t5 bus_rd at QLEN-2", 32'(bus_rd), 32'd1);
    consume(2'd3);
    chk("t5 bus_rd refill", 32'(bus_rd), 32'd1);

    // Reset mid-fill, with an ack arriving during reset
    chk("t6 bus_rd before rst", 32'(bus_rd), 32'd1);
    rst = 1'b1;
    tick();
    chk_reset_outputs("t6");
    rst = 1'b0;
    tick();
    chk("t6 first bus_rd", 32'(bus_rd), 32'd1);
    chk("t6 first bus_addr", 32'(bus_addr), 32'd0);
    tick();
    tick();
    chk("t6 op_ok", 32'(op_ok), 32'd1);
    chk("t6 op", op, exp_op(24'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
